// File: rtl/sample_framer_pkg.sv
// Shared definitions for the sample framer.
//   state_t   : framer FSM states, in transmit order
//   SYNC_BYTE : frame header byte; it is not covered by the checksum
//   SAMPLE_W  : width of one filtered sample
package sample_framer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SEQ,
    DATA_HI,
    DATA_LO,
    CSUM
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         SAMPLE_W  = 16;

endpackage

// File: rtl/sample_fifo.sv
// Circular sample buffer.
//   clk, reset : clock, asynchronous active-high reset (clears pointers and count)
//   push       : write push_data this cycle (ignored when full)
//   push_data  : word to write
//   pop        : retire the head entry this cycle (ignored when empty)
//   head       : oldest stored word
//   head_next  : word behind the head, so a caller can present it at the pop edge
//   count      : number of stored words, 0..DEPTH
module sample_fifo #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 8,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [DATA_W-1:0] head_next,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push   = push && (count != CW'(DEPTH));
  assign do_pop    = pop && (count != '0);
  assign head      = mem[rd_ptr];
  assign head_next = mem[wrap_inc(rd_ptr)];

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wrap_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= wrap_inc(rd_ptr);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/sample_framer.sv
// Packs buffered 16-bit samples into byte frames:
//   A5, SEQ, {hi, lo} x FRAME_LEN, CSUM  (CSUM = XOR of SEQ and all sample bytes)
//   clk, reset  : clock, asynchronous active-high reset
//   in_valid    : in_data holds a new sample (no backpressure; dropped when full)
//   in_data     : signed 16-bit sample
//   tx_data     : registered frame byte
//   tx_valid    : registered, high in every state except IDLE
//   tx_ready    : byte sink accepts tx_data this cycle
//   frame_done  : high during the cycle the checksum byte is accepted
//   overflow    : sticky, set when a sample is dropped; cleared only by reset
module sample_framer
  import sample_framer_pkg::*;
#(
  parameter int FRAME_LEN  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic signed [15:0] in_data,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               frame_done,
  output logic               overflow
);

  localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_LEN);
  localparam logic [4:0]    LAST_IDX  = 5'(FRAME_LEN - 1);

  state_t              state;
  logic [CW-1:0]       fifo_count;
  logic [SAMPLE_W-1:0] head;
  logic [SAMPLE_W-1:0] head_next;
  logic [7:0]          seq_num;
  logic [7:0]          csum;
  logic [7:0]          csum_acc;
  logic [4:0]          sample_idx;
  logic                push;
  logic                pop;
  logic                hs;

  assign hs         = tx_valid & tx_ready;
  assign push       = in_valid & (fifo_count != FULL_CNT);
  assign pop        = hs & (state == DATA_LO);
  assign csum_acc   = csum ^ tx_data;
  assign frame_done = hs & (state == CSUM);

  sample_fifo #(
    .DATA_W (SAMPLE_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ($unsigned(in_data)),
    .pop       (pop),
    .head      (head),
    .head_next (head_next),
    .count     (fifo_count)
  );

  // A full buffer drops the sample even when a pop frees a slot this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (in_valid && (fifo_count == FULL_CNT)) begin
      overflow <= 1'b1;
    end
  end

  // Each state presents its byte; on the handshake the next state's byte is
  // loaded so tx_data/tx_valid stay registered and stable under stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      seq_num    <= '0;
      csum       <= '0;
      sample_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_count >= FRAME_CNT) begin
            state    <= HDR;
            tx_valid <= 1'b1;
            tx_data  <= SYNC_BYTE;
          end
        end
        HDR: begin
          if (hs) begin
            state   <= SEQ;
            tx_data <= seq_num;
          end
        end
        SEQ: begin
          if (hs) begin
            state      <= DATA_HI;
            tx_data    <= head[15:8];
            csum       <= seq_num;
            sample_idx <= '0;
          end
        end
        DATA_HI: begin
          if (hs) begin
            state   <= DATA_LO;
            tx_data <= head[7:0];
            csum    <= csum_acc;
          end
        end
        DATA_LO: begin
          // The head is popped on this edge, so the next sample is read
          // from the entry behind it.
          if (hs) begin
            csum <= csum_acc;
            if (sample_idx == LAST_IDX) begin
              state   <= CSUM;
              tx_data <= csum_acc;
            end else begin
              state      <= DATA_HI;
              tx_data    <= head_next[15:8];
              sample_idx <= sample_idx + 1'b1;
            end
          end
        end
        CSUM: begin
          if (hs) begin
            seq_num <= seq_num + 1'b1;
            if (fifo_count >= FRAME_CNT) begin
              state   <= HDR;
              tx_data <= SYNC_BYTE;
            end else begin
              state    <= IDLE;
              tx_valid <= 1'b0;
              tx_data  <= '0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
          tx_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/sample_framer.md
SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 4, giving the number of 16-bit samples per frame (legal range 1..16).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, giving the sample buffer depth (power of two, at least FRAME_LEN).
REQ-003 The block SHALL have port clk, input, 1 bit: clock, rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data carries a new filtered sample this cycle.
REQ-006 The block SHALL have port in_data, input, 16 bits: signed filtered sample, two's complement.
REQ-007 The block SHALL have port tx_data, output, 8 bits: current frame byte.
REQ-008 The block SHALL have port tx_valid, output, 1 bit: tx_data is valid.
REQ-009 The block SHALL have port tx_ready, input, 1 bit: the byte sink accepts tx_data this cycle.
REQ-010 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when the checksum byte is accepted.
REQ-011 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a sample is dropped.

Function
REQ-012 Samples SHALL be written to the FIFO on clk when in_valid=1 and the registered count is less than FIFO_DEPTH; there is no input backpressure.
REQ-013 If in_valid=1 and the count equals FIFO_DEPTH, the sample SHALL be dropped and overflow set, even if a pop occurs in the same cycle.
REQ-014 The frame SHALL be, in order: 0xA5, SEQ, then for each sample its high byte followed by its low byte, then CSUM; the frame length is 3+2*FRAME_LEN bytes.
REQ-015 CSUM SHALL be the bitwise XOR of SEQ and all sample bytes; the 0xA5 header is excluded.
REQ-016 SEQ SHALL be an 8-bit counter, reset to 0x00, incremented when the CSUM byte is accepted, and wrapping from 0xFF to 0x00.
REQ-017 The FSM SHALL have the states IDLE, HDR, SEQ, DATA_HI, DATA_LO and CSUM.
REQ-018 IDLE SHALL go to HDR when count is at least FRAME_LEN, so that a frame never starts without all its samples buffered.
REQ-019 The FSM SHALL step HDR to SEQ to DATA_HI, DATA_HI to DATA_LO, and DATA_LO to DATA_HI while samples remain, otherwise to CSUM; each step requires a handshake (tx_valid and tx_ready).
REQ-020 The FIFO head SHALL be popped on the handshake of the DATA_LO byte.
REQ-021 On the CSUM handshake, the FSM SHALL go directly to HDR if count (after the pop) is at least FRAME_LEN, otherwise to IDLE; no idle gap is permitted between back-to-back frames.
REQ-022 tx_valid SHALL be 1 in every state except IDLE.
REQ-023 tx_data and tx_valid SHALL be held stable while tx_valid=1 and tx_ready=0.
REQ-024 tx_data and tx_valid SHALL be registered outputs.
REQ-025 tx_valid SHALL rise in the cycle after the edge at which count first reaches FRAME_LEN.
REQ-026 Simultaneous push and pop SHALL leave count unchanged, and both operations SHALL take effect.
REQ-027 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 Reset SHALL clear the FIFO (count=0), the FSM (to IDLE), SEQ (to 0x00) and the running CSUM.
REQ-029 During reset the outputs SHALL be tx_valid=0, tx_data=0x00, frame_done=0 and overflow=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately, with no further bytes of it emitted.
REQ-031 overflow SHALL be cleared only by reset.

Structure
REQ-032 Package sample_framer_pkg SHALL hold the FSM state enum and the constant SYNC_BYTE = 0xA5.
REQ-033 The FIFO SHALL be a sub-module named sample_fifo, parameterised by width and depth, providing push, pop, head data and count.
REQ-034 The FSM, the sample counter, SEQ and the CSUM accumulator SHALL reside in sample_framer.

Verification
REQ-035 With FRAME_LEN=4, tx_ready=1 and samples 0x1234, 0xFFFE, 0x0001, 0x8000, the bench SHALL see bytes A5 00 12 34 FF FE 00 01 80 00 A6 and frame_done pulsing on A6.
REQ-036 With tx_ready held at 0 for 5 cycles while DATA_HI=0xFF is presented, tx_data SHALL stay 0xFF and tx_valid SHALL stay 1 for those 5 cycles, with no pop.
REQ-037 With tx_ready=0 and 9 consecutive samples, 8 SHALL be stored, the 9th dropped, and overflow=1; overflow SHALL remain 1 after draining.
REQ-038 With 8 samples and tx_ready=1, two frames SHALL be emitted with SEQ 0x00 and 0x01, and HDR SHALL follow CSUM on the next cycle.
REQ-039 With reset asserted during the DATA_LO of the second sample, the next cycle SHALL show tx_valid=0, and a fresh 4 samples SHALL yield a frame with SEQ=0x00.
REQ-040 After 256 frames, the 257th frame SHALL carry SEQ=0x00.
